// File: rtl/params_pkg.sv
// Display geometry and colour depth shared by the panel scan logic and its framebuffer.
package params_pkg;
  localparam int PIXEL_WIDTH       = 64;
  localparam int PIXEL_HALFHEIGHT  = 16;
  localparam int BRIGHTNESS_LEVELS = 8;
endpackage

// File: rtl/hub75_scan_controller_if.sv
// Framebuffer fetch port: scan engine drives the address, framebuffer answers one cycle later.
interface hub75_scan_controller_if #(
  parameter int COL_W = $clog2(params_pkg::PIXEL_WIDTH),
  parameter int ROW_W = (params_pkg::PIXEL_HALFHEIGHT > 1) ? $clog2(params_pkg::PIXEL_HALFHEIGHT) : 1,
  parameter int BP_W  = (params_pkg::BRIGHTNESS_LEVELS > 1) ? $clog2(params_pkg::BRIGHTNESS_LEVELS) : 1
) ();
  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row_addr;
  logic [BP_W-1:0]  bitplane;
  logic [2:0]       rgb_top;
  logic [2:0]       rgb_bot;

  modport master (output column, output row_addr, output bitplane,
                  input rgb_top, input rgb_bot);
  modport slave  (input column, input row_addr, input bitplane,
                  output rgb_top, output rgb_bot);
endinterface

// File: rtl/hub75_scan_controller.sv
// HUB75 scan engine: fetches and shifts one row-plane, latches it, then lights it with
// binary-coded-modulation OE timing (bitplane b is lit for OE_BASE_CYCLES<<b cycles).
module hub75_scan_controller #(
  parameter int PIXEL_WIDTH       = params_pkg::PIXEL_WIDTH,
  parameter int PIXEL_HALFHEIGHT  = params_pkg::PIXEL_HALFHEIGHT,
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int OE_BASE_CYCLES    = 4,
  localparam int COL_W = $clog2(PIXEL_WIDTH),
  localparam int ROW_W = (PIXEL_HALFHEIGHT > 1) ? $clog2(PIXEL_HALFHEIGHT) : 1,
  localparam int BP_W  = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1
) (
  input  logic                    clk_root,
  input  logic                    reset_n,
  input  logic                    enable,
  hub75_scan_controller_if.master fb,
  output logic                    hub75_clk,
  output logic [2:0]              hub75_rgb0,
  output logic [2:0]              hub75_rgb1,
  output logic                    hub75_latch,
  output logic                    hub75_oe_n,
  output logic [ROW_W-1:0]        hub75_row,
  output logic                    frame_start
);

  // One counter serves both the shift phases and the OE window, so size it for the longer.
  localparam int OE_MAX  = OE_BASE_CYCLES << (BRIGHTNESS_LEVELS - 1);
  localparam int CNT_MAX = (OE_MAX > 2 * PIXEL_WIDTH) ? OE_MAX : 2 * PIXEL_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   oe_len;
  logic [COL_W-1:0]   column_q, column_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BP_W-1:0]    bp_q, bp_d;
  logic [2:0]         rgb0_q, rgb0_d;
  logic [2:0]         rgb1_q, rgb1_d;
  logic [ROW_W-1:0]   hrow_q, hrow_d;
  logic               hclk_q, hclk_d;
  logic               latch_q, latch_d;
  logic               oe_n_q, oe_n_d;
  logic               fs_q, fs_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    column_d = column_q;
    row_d    = row_q;
    bp_d     = bp_q;
    rgb0_d   = rgb0_q;
    rgb1_d   = rgb1_q;
    hrow_d   = hrow_q;
    oe_len   = CNT_W'(OE_BASE_CYCLES) << bp_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = PREFETCH;
          column_d = '0;
        end
      end
      PREFETCH: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Even counts are phase 0: pixel data for the address of the previous cycle arrives now.
        if (!cnt_q[0]) begin
          rgb0_d = fb.rgb_top;
          rgb1_d = fb.rgb_bot;
          if (column_q != COL_W'(PIXEL_WIDTH - 1)) begin
            column_d = column_q + COL_W'(1);
          end
        end
        if (cnt_q == CNT_W'(2 * PIXEL_WIDTH - 1)) begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        state_d = LATCH;
        hrow_d  = row_q;
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Counters advance even when stopping, so a later enable resumes at the next row-plane.
        if (cnt_q == oe_len - CNT_W'(1)) begin
          cnt_d    = '0;
          column_d = '0;
          if (bp_q == BP_W'(BRIGHTNESS_LEVELS - 1)) begin
            bp_d  = '0;
            row_d = (row_q == ROW_W'(PIXEL_HALFHEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
          end else begin
            bp_d = bp_q + BP_W'(1);
          end
          state_d = enable ? PREFETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hclk_d  = (state_d == SHIFT) && cnt_d[0];
    latch_d = (state_d == LATCH);
    oe_n_d  = (state_d != DISPLAY);
    fs_d    = (state_d == PREFETCH) && (row_d == '0) && (bp_d == '0);
  end

  always_ff @(posedge clk_root or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      column_q <= '0;
      row_q    <= '0;
      bp_q     <= '0;
      rgb0_q   <= '0;
      rgb1_q   <= '0;
      hrow_q   <= '0;
      hclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      oe_n_q   <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      column_q <= column_d;
      row_q    <= row_d;
      bp_q     <= bp_d;
      rgb0_q   <= rgb0_d;
      rgb1_q   <= rgb1_d;
      hrow_q   <= hrow_d;
      hclk_q   <= hclk_d;
      latch_q  <= latch_d;
      oe_n_q   <= oe_n_d;
      fs_q     <= fs_d;
    end
  end

  assign fb.column    = column_q;
  assign fb.row_addr  = row_q;
  assign fb.bitplane  = bp_q;
  assign hub75_clk    = hclk_q;
  assign hub75_rgb0   = rgb0_q;
  assign hub75_rgb1   = rgb1_q;
  assign hub75_latch  = latch_q;
  assign hub75_oe_n   = oe_n_q;
  assign hub75_row    = hrow_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Bench for hub75_scan_controller: a row-plane timeline model predicts every output each cycle,
// fed by a framebuffer model with one cycle of read latency.
module tb_hub75_scan_controller;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int B  = 2;
  localparam int OE = 2;

  localparam int K_IDLE = 0, K_PRE = 1, K_SHIFT = 2, K_BLANK = 3, K_LATCH = 4, K_DISP = 5;

  typedef struct {
    int         kind;
    logic       hclk;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic       latch;
    logic       oe_n;
    logic       fs;
    int         hrow;
    int         col;
    int         row;
    int         bp;
  } exp_t;

  logic       clk_root = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       hub75_clk;
  logic [2:0] hub75_rgb0;
  logic [2:0] hub75_rgb1;
  logic       hub75_latch;
  logic       hub75_oe_n;
  logic [0:0] hub75_row;
  logic       frame_start;

  hub75_scan_controller_if #(.COL_W(2), .ROW_W(1), .BP_W(1)) fb ();

  hub75_scan_controller #(
    .PIXEL_WIDTH(W), .PIXEL_HALFHEIGHT(H), .BRIGHTNESS_LEVELS(B), .OE_BASE_CYCLES(OE)
  ) dut (
    .clk_root(clk_root), .reset_n(reset_n), .enable(enable), .fb(fb),
    .hub75_clk(hub75_clk), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
    .hub75_latch(hub75_latch), .hub75_oe_n(hub75_oe_n), .hub75_row(hub75_row),
    .frame_start(frame_start)
  );

  always #5 clk_root = ~clk_root;

  logic [2:0] mem_top [B][H][W];
  logic [2:0] mem_bot [B][H][W];
  logic [2:0] pend_top = 3'd0;
  logic [2:0] pend_bot = 3'd0;

  // Framebuffer: address seen during one cycle is answered during the next.
  always @(negedge clk_root) begin
    pend_top = mem_top[fb.bitplane][fb.row_addr][fb.column];
    pend_bot = mem_bot[fb.bitplane][fb.row_addr][fb.column];
  end
  always @(posedge clk_root) begin
    #2;
    fb.rgb_top = pend_top;
    fb.rgb_bot = pend_bot;
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_kind = K_IDLE;
  bit   tracking = 0;
  int   oe_run = 0;
  int   fs_cycles[$];
  int   latch_cycles[$];
  int   latch_rows[$];
  int   oe_runs[$];
  exp_t exp_q[$];

  int         m_row = 0;
  int         m_bp = 0;
  int         m_hrow = 0;
  logic [2:0] m_rgb0 = 3'd0;
  logic [2:0] m_rgb1 = 3'd0;

  int want_rows[5] = '{0, 0, 1, 1, 0};
  int want_runs[4] = '{2, 4, 2, 4};

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t base_rec(input int kind, input int r, input int p, input int col);
    exp_t e;
    e.kind  = kind;
    e.hclk  = 1'b0;
    e.rgb0  = m_rgb0;
    e.rgb1  = m_rgb1;
    e.latch = 1'b0;
    e.oe_n  = 1'b1;
    e.fs    = 1'b0;
    e.hrow  = m_hrow;
    e.col   = col;
    e.row   = r;
    e.bp    = p;
    return e;
  endfunction

  // Whole row-plane timeline: prefetch, W column pairs, blank, latch, OE window.
  function automatic void push_row_plane();
    exp_t e;
    int   r;
    int   p;
    r = m_row;
    p = m_bp;
    e = base_rec(K_PRE, r, p, 0);
    e.fs = (r == 0 && p == 0);
    exp_q.push_back(e);
    for (int c = 0; c < W; c++) begin
      e = base_rec(K_SHIFT, r, p, c);
      exp_q.push_back(e);
      m_rgb0 = mem_top[p][r][c];
      m_rgb1 = mem_bot[p][r][c];
      e = base_rec(K_SHIFT, r, p, (c + 1 < W) ? c + 1 : W - 1);
      e.hclk = 1'b1;
      exp_q.push_back(e);
    end
    exp_q.push_back(base_rec(K_BLANK, r, p, W - 1));
    m_hrow = r;
    e = base_rec(K_LATCH, r, p, W - 1);
    e.latch = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < (OE << p); k++) begin
      e = base_rec(K_DISP, r, p, W - 1);
      e.oe_n = 1'b0;
      exp_q.push_back(e);
    end
    m_bp = (p + 1) % B;
    if (m_bp == 0) m_row = (r + 1) % H;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_row  = 0;
    m_bp   = 0;
    m_hrow = 0;
    m_rgb0 = 3'd0;
    m_rgb1 = 3'd0;
  endtask

  task automatic step_cycle();
    exp_t e;
    @(posedge clk_root);
    #1;
    cyc++;
    if (exp_q.size() == 0 && enable) push_row_plane();
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = base_rec(K_IDLE, m_row, m_bp, 0);
    last_kind = e.kind;
    check_output("hub75_clk",   hub75_clk,   e.hclk);
    check_output("hub75_rgb0",  hub75_rgb0,  e.rgb0);
    check_output("hub75_rgb1",  hub75_rgb1,  e.rgb1);
    check_output("hub75_latch", hub75_latch, e.latch);
    check_output("hub75_oe_n",  hub75_oe_n,  e.oe_n);
    check_output("hub75_row",   hub75_row,   e.hrow);
    check_output("frame_start", frame_start, e.fs);
    check_output("column",      fb.column,   e.col);
    check_output("row_addr",    fb.row_addr, e.row);
    check_output("bitplane",    fb.bitplane, e.bp);
    if (tracking) begin
      if (frame_start) fs_cycles.push_back(cyc);
      if (hub75_latch) begin
        latch_cycles.push_back(cyc);
        latch_rows.push_back(int'(hub75_row));
      end
      if (!hub75_oe_n) oe_run++;
      else if (oe_run > 0) begin
        oe_runs.push_back(oe_run);
        oe_run = 0;
      end
    end
  endtask

  task automatic apply_stimulus(input bit en, input int n);
    for (int i = 0; i < n; i++) begin
      enable = en;
      step_cycle();
    end
  endtask

  task automatic check_reset_state();
    check_output("rst_oe_n",     hub75_oe_n,  1);
    check_output("rst_clk",      hub75_clk,   0);
    check_output("rst_latch",    hub75_latch, 0);
    check_output("rst_rgb0",     hub75_rgb0,  0);
    check_output("rst_rgb1",     hub75_rgb1,  0);
    check_output("rst_row",      hub75_row,   0);
    check_output("rst_fs",       frame_start, 0);
    check_output("rst_column",   fb.column,   0);
    check_output("rst_row_addr", fb.row_addr, 0);
    check_output("rst_bitplane", fb.bitplane, 0);
  endtask

  initial begin
    int latches_in_frame;
    bit found;
    reset_n = 1'b0;
    enable  = 1'b0;
    fb.rgb_top = 3'd0;
    fb.rgb_bot = 3'd0;
    for (int p = 0; p < B; p++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          mem_top[p][r][c] = 3'(c);
          mem_bot[p][r][c] = ~3'(c);
        end

    repeat (2) @(posedge clk_root);
    @(negedge clk_root);
    check_reset_state();
    $display("[TB] releasing reset with enable high");
    enable   = 1'b1;
    reset_n  = 1'b1;
    cyc      = 0;
    tracking = 1;
    apply_stimulus(1, 115);
    tracking = 0;

    check_output("first_frame_start", fs_cycles[0], 1);
    check_output("frame_period", fs_cycles[1] - fs_cycles[0], 56);
    latches_in_frame = 0;
    foreach (latch_cycles[i])
      if (latch_cycles[i] >= fs_cycles[0] && latch_cycles[i] < fs_cycles[1]) latches_in_frame++;
    check_output("latches_per_frame", latches_in_frame, 4);
    for (int i = 0; i < 5; i++) check_output("latch_row_seq", latch_rows[i], want_rows[i]);
    for (int i = 0; i < 4; i++) check_output("oe_low_run", oe_runs[i], want_runs[i]);

    $display("[TB] dropping enable during shift of row 1, plane 0");
    apply_stimulus(1, 28);
    apply_stimulus(0, 40);
    check_output("stop_oe_n", hub75_oe_n, 1);
    check_output("stop_row_addr", fb.row_addr, 1);
    check_output("stop_bitplane", fb.bitplane, 1);

    for (int p = 0; p < B; p++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          mem_top[p][r][c] = 3'($urandom);
          mem_bot[p][r][c] = 3'($urandom);
        end
    $display("[TB] re-enabling with random framebuffer and random enable");
    apply_stimulus(1, 20);
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      step_cycle();
    end

    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      enable = 1'b1;
      step_cycle();
      if (last_kind == K_DISP) found = 1;
    end
    check_output("display_reached", found, 1);
    $display("[TB] pulsing reset_n during display");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state();
    reset_model();
    @(posedge clk_root);
    @(negedge clk_root);
    reset_n = 1'b1;
    cyc     = 0;
    apply_stimulus(1, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
